// File: rtl/dmem_bus_responder.sv
// Load/store responder for the multicycle core: RAM plus GPIO/CYCLE MMIO,
// one request at a time with a fixed programmable response latency.
module dmem_bus_responder #(
    parameter int unsigned DEPTH_WORDS = 2048,
    parameter int unsigned WAIT_STATES = 1,
    parameter logic [31:0] MMIO_BASE   = 32'hFFFF_FFF0,
    // Reset value of CYCLE; nonzero only to exercise the wrap quickly
    parameter logic [31:0] CYCLE_RESET = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_error,
    output logic [7:0]  gpio_out
);

    localparam int IW = $clog2(DEPTH_WORDS);
    localparam int unsigned WSL = (WAIT_STATES == 0) ? 0 : WAIT_STATES - 1;
    localparam logic [3:0] WS_LAST = WSL[3:0];

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t      state_q;
    state_t      state_d;
    logic [3:0]  wcnt_q;
    logic        wr_q;
    logic [2:0]  f3_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] rword_q;
    logic [31:0] cycle_q;
    logic [7:0]  gpio_q;
    logic [31:0] ram [DEPTH_WORDS];

    logic        accept;
    logic        commit;
    logic        hit_ram;
    logic        hit_gpio;
    logic        hit_cyc;
    logic        bad_f3;
    logic        misal;
    logic        err;
    logic [31:0] src;
    logic [31:0] bsh;
    logic [15:0] half;
    logic [31:0] load_data;
    logic [3:0]  be;
    logic [31:0] wd;
    logic [IW-1:0] widx;

    assign accept = req_valid && req_ready;
    assign commit = (state_q == S_RESP) && wr_q && !err;
    assign widx   = addr_q[IW+1:2];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    state_d = (WAIT_STATES == 0) ? S_RESP : S_WAIT;
                end
            end
            S_WAIT: begin
                if (wcnt_q == WS_LAST) begin
                    state_d = S_RESP;
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        req_ready = (state_q == S_IDLE);
        rsp_valid = (state_q == S_RESP);
        rsp_error = rsp_valid && err;
        rsp_rdata = (rsp_valid && !err && !wr_q) ? load_data : 32'h0;
        gpio_out  = gpio_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wcnt_q  <= 4'd0;
            wr_q    <= 1'b0;
            f3_q    <= 3'd0;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            cycle_q <= CYCLE_RESET;
            gpio_q  <= 8'h0;
        end else begin
            cycle_q <= cycle_q + 32'd1;
            if (accept) begin
                wr_q    <= req_write;
                f3_q    <= req_funct3;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
                wcnt_q  <= 4'd0;
            end else if (state_q == S_WAIT) begin
                wcnt_q <= wcnt_q + 4'd1;
            end
            if (commit && hit_gpio) begin
                gpio_q <= wdata_q[7:0];
            end
        end
    end

    // Read at accept: any earlier store already committed on its RESP exit
    always_ff @(posedge clk) begin
        if (commit && hit_ram) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) begin
                    ram[widx][8*i +: 8] <= wd[8*i +: 8];
                end
            end
        end
        if (accept) begin
            rword_q <= ram[req_addr[IW+1:2]];
        end
    end

    always_comb begin
        hit_ram  = ({2'b00, addr_q[31:2]} < DEPTH_WORDS);
        hit_gpio = (addr_q[31:2] == MMIO_BASE[31:2]);
        hit_cyc  = (addr_q[31:2] == MMIO_BASE[31:2] + 30'd1);
        if (wr_q) begin
            bad_f3 = (f3_q > 3'd2);
        end else begin
            bad_f3 = (f3_q == 3'd3) || (f3_q == 3'd6) || (f3_q == 3'd7);
        end
        misal = ((f3_q[1:0] == 2'd1) && addr_q[0])
             || ((f3_q[1:0] == 2'd2) && (addr_q[1:0] != 2'd0));
        err = bad_f3 || misal
           || !(hit_ram || hit_gpio || hit_cyc)
           || ((hit_gpio || hit_cyc) && (f3_q[1:0] != 2'd2))
           || (wr_q && hit_cyc);
    end

    always_comb begin
        src = rword_q;
        unique case (1'b1)
            hit_gpio: src = {24'h0, gpio_q};
            hit_cyc:  src = cycle_q;
            default:  src = rword_q;
        endcase
        bsh  = src >> {addr_q[1:0], 3'b000};
        half = addr_q[1] ? src[31:16] : src[15:0];
        unique case (f3_q)
            3'd0:    load_data = {{24{bsh[7]}}, bsh[7:0]};
            3'd1:    load_data = {{16{half[15]}}, half};
            3'd4:    load_data = {24'h0, bsh[7:0]};
            3'd5:    load_data = {16'h0, half};
            default: load_data = src;
        endcase
    end

    always_comb begin
        unique case (f3_q[1:0])
            2'd0: begin
                be = 4'b0001 << addr_q[1:0];
                wd = {4{wdata_q[7:0]}};
            end
            2'd1: begin
                be = addr_q[1] ? 4'b1100 : 4'b0011;
                wd = {2{wdata_q[15:0]}};
            end
            default: begin
                be = 4'b1111;
                wd = wdata_q;
            end
        endcase
    end

endmodule
